// File: rtl/parity_step_counter_pkg.sv
// Shared encodings for the parity step counter: sequence parity, count
// direction and the per-cycle action chosen by the priority mux.
package parity_step_counter_pkg;

    typedef enum logic {
        MODE_EVEN = 1'b0,
        MODE_ODD  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_MODE,
        ACT_LOAD,
        ACT_UP,
        ACT_DOWN
    } action_e;

    localparam int STEP = 2;

endpackage

// File: rtl/parity_limit_calc.sv
// Combinational range bounds for the current parity: base is the smallest
// value of that parity, top the largest value of that parity not above lim.
module parity_limit_calc
    import parity_step_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] lim,
    input  logic             mode_q,
    output logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] top
);

    logic [WIDTH-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch can be inferred.
        base = {{(WIDTH-1){1'b0}}, mode_q};
        cand = {lim[WIDTH-1:1], mode_q};
        top  = cand;
        // cand only exceeds lim in odd mode with an even lim, so lim >= 2 there.
        if (lim < base) begin
            top = base;
        end else if (cand > lim) begin
            top = cand - WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/parity_step_counter.sv
// Even/odd step-by-two counter with direction, inclusive limit, parallel
// load, enable and a registered wrap pulse. All state is synchronously reset.
module parity_step_counter
    import parity_step_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] lim,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    logic             mode_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] top;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] down_diff;
    logic [WIDTH-1:0] load_aligned;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_d;
    action_e          action;

    parity_limit_calc #(
        .WIDTH(WIDTH)
    ) u_limit (
        .lim    (lim),
        .mode_q (mode_q),
        .base   (base),
        .top    (top)
    );

    assign up_sum       = {1'b0, cnt} + (WIDTH+1)'(STEP);
    assign down_diff    = cnt - WIDTH'(STEP);
    assign load_aligned = {load_val[WIDTH-1:1], mode_q};

    always_comb begin
        action = ACT_HOLD;
        if (mode != mode_q) begin
            action = ACT_MODE;
        end else if (load) begin
            action = ACT_LOAD;
        end else if (en) begin
            action = (dir == DIR_DOWN) ? ACT_DOWN : ACT_UP;
        end
    end

    always_comb begin
        cnt_d  = cnt;
        wrap_d = 1'b0;
        unique case (action)
            ACT_MODE: cnt_d = {{(WIDTH-1){1'b0}}, mode};
            ACT_LOAD: cnt_d = (load_aligned > top) ? top : load_aligned;
            ACT_UP: begin
                // A carry out also wraps, so the sum can never alias to a small value.
                if (cnt >= top || up_sum[WIDTH]) begin
                    cnt_d  = base;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = up_sum[WIDTH-1:0];
                end
            end
            ACT_DOWN: begin
                if (cnt <= base) begin
                    cnt_d  = top;
                    wrap_d = 1'b1;
                end else if (cnt > top) begin
                    // Limit was lowered beneath the count: snap to the new top.
                    cnt_d = top;
                end else begin
                    cnt_d = down_diff;
                end
            end
            default: cnt_d = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            mode_q <= MODE_EVEN;
            cnt    <= '0;
            wrap   <= 1'b0;
        end else begin
            mode_q <= mode;
            cnt    <= cnt_d;
            wrap   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_parity_step_counter.sv
// Directed bench for parity_step_counter (WIDTH=4): a vector table of
// per-cycle inputs and expected outputs, then hand-written corner sequences.
module tb_parity_step_counter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] lim;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt;
    logic             wrap;

    typedef struct {
        string            name;
        logic             rst;
        logic             en;
        logic             mode;
        logic             dir;
        logic [WIDTH-1:0] lim;
        logic             load;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] exp_cnt;
        logic             exp_wrap;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic model_mode = 1'b0;

    always #5 clk = ~clk;

    parity_step_counter #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .lim      (lim),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .wrap     (wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input string name, input int r, input int e, input int m, input int d,
                       input int l, input int ld, input int lv, input int ec, input int ew);
        vec_t v;
        v.name     = name;
        v.rst      = 1'(r);
        v.en       = 1'(e);
        v.mode     = 1'(m);
        v.dir      = 1'(d);
        v.lim      = 4'(l);
        v.load     = 1'(ld);
        v.load_val = 4'(lv);
        v.exp_cnt  = 4'(ec);
        v.exp_wrap = 1'(ew);
        vecs.push_back(v);
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge,
    // and confirm the count's LSB matches the parity the bench expects.
    task automatic step(input string name, input logic r, input logic e, input logic m,
                        input logic d, input logic [WIDTH-1:0] l, input logic ld,
                        input logic [WIDTH-1:0] lv);
        @(negedge clk);
        rst      = r;
        en       = e;
        mode     = m;
        dir      = d;
        lim      = l;
        load     = ld;
        load_val = lv;
        @(posedge clk);
        #1;
        model_mode = r ? 1'b0 : m;
        check($sformatf("%s parity", name), {31'd0, cnt[0]}, {31'd0, model_mode});
    endtask

    task automatic expect_out(input string name, input int ec, input int ew);
        check($sformatf("%s cnt", name), {28'd0, cnt}, ec);
        check($sformatf("%s wrap", name), {31'd0, wrap}, ew);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0;
        lim = '0; load = 1'b0; load_val = '0;

        // Reset, then even count up through the full range and wrap once.
        add("reset", 1, 0, 0, 0, 15, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) add($sformatf("even_up%0d", i), 0, 1, 0, 0, 15, 0, 0, 2*i, 0);
        add("even_wrap", 0, 1, 0, 0, 15, 0, 0, 0, 1);
        add("even_post_wrap", 0, 1, 0, 0, 15, 0, 0, 2, 0);
        add("even_to4", 0, 1, 0, 0, 15, 0, 0, 4, 0);
        add("even_to6", 0, 1, 0, 0, 15, 0, 0, 6, 0);
        // Mode change at cnt=6, then odd sequence to 15 and wrap to 1.
        add("to_odd", 0, 1, 1, 0, 15, 0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) add($sformatf("odd_up%0d", i), 0, 1, 1, 0, 15, 0, 0, 2*i+1, 0);
        add("odd_wrap", 0, 1, 1, 0, 15, 0, 0, 1, 1);
        // Load 12 in odd mode with lim=10: forced to 13, clamped to top 9.
        add("load_clamp", 0, 1, 1, 1, 10, 1, 12, 9, 0);
        add("odd_dn7", 0, 1, 1, 1, 10, 0, 0, 7, 0);
        add("odd_dn5", 0, 1, 1, 1, 10, 0, 0, 5, 0);
        add("odd_dn3", 0, 1, 1, 1, 10, 0, 0, 3, 0);
        add("odd_dn1", 0, 1, 1, 1, 10, 0, 0, 1, 0);
        add("odd_dn_wrap", 0, 1, 1, 1, 10, 0, 0, 9, 1);
        // Mode change beats load and en; reset beats everything.
        add("to_even", 0, 0, 0, 0, 10, 0, 0, 0, 0);
        add("mode_over_load", 0, 1, 1, 0, 10, 1, 8, 1, 0);
        add("back_even", 0, 0, 0, 0, 10, 0, 0, 0, 0);
        add("rst_over_all", 1, 1, 1, 0, 10, 1, 8, 0, 0);
        add("after_rst_even", 0, 1, 0, 0, 15, 0, 0, 2, 0);
        // Odd mode with lim=0: top collapses to base, every step wraps.
        add("odd_lim0", 0, 0, 1, 0, 0, 0, 0, 1, 0);
        add("lim0_up", 0, 1, 1, 0, 0, 0, 0, 1, 1);
        add("lim0_dn", 0, 1, 1, 1, 0, 0, 0, 1, 1);
        add("lim0_up2", 0, 1, 1, 0, 0, 0, 0, 1, 1);
        // lim lowered beneath cnt: next up step wraps, then hold clears wrap.
        add("even_again", 0, 0, 0, 0, 15, 0, 0, 0, 0);
        add("load12", 0, 0, 0, 0, 15, 1, 12, 12, 0);
        add("lim_lowered_up", 0, 1, 0, 0, 6, 0, 0, 0, 1);
        add("hold", 0, 0, 0, 0, 6, 0, 0, 0, 0);
        // Even mode lim=1 (top 0), and load alignment / clamp to max.
        add("lim1_up", 0, 1, 0, 0, 1, 0, 0, 0, 1);
        add("load5_even", 0, 0, 0, 0, 15, 1, 5, 4, 0);
        add("load15_even", 0, 1, 0, 1, 15, 1, 15, 14, 0);
        add("even_dn12", 0, 1, 0, 1, 15, 0, 0, 12, 0);

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].dir,
                 vecs[i].lim, vecs[i].load, vecs[i].load_val);
            expect_out(vecs[i].name, int'(vecs[i].exp_cnt), int'(vecs[i].exp_wrap));
        end

        // Down count with lim lowered beneath cnt: snap to top without wrap.
        step("seqA_load", 0, 0, 0, 0, 4'd15, 1, 4'd12);  expect_out("seqA_load", 12, 0);
        step("seqA_snap", 0, 1, 0, 1, 4'd6, 0, 4'd0);    expect_out("seqA_snap", 6, 0);
        step("seqA_dn4", 0, 1, 0, 1, 4'd6, 0, 4'd0);     expect_out("seqA_dn4", 4, 0);
        step("seqA_dn2", 0, 1, 0, 1, 4'd6, 0, 4'd0);     expect_out("seqA_dn2", 2, 0);
        step("seqA_dn0", 0, 1, 0, 1, 4'd6, 0, 4'd0);     expect_out("seqA_dn0", 0, 0);
        step("seqA_wrap", 0, 1, 0, 1, 4'd6, 0, 4'd0);    expect_out("seqA_wrap", 6, 1);

        // Direction toggling every cycle, including back-to-back wraps.
        step("seqB_odd", 0, 0, 1, 0, 4'd15, 0, 4'd0);    expect_out("seqB_odd", 1, 0);
        step("seqB_up3", 0, 1, 1, 0, 4'd15, 0, 4'd0);    expect_out("seqB_up3", 3, 0);
        step("seqB_dn1", 0, 1, 1, 1, 4'd15, 0, 4'd0);    expect_out("seqB_dn1", 1, 0);
        step("seqB_dnwrap", 0, 1, 1, 1, 4'd15, 0, 4'd0); expect_out("seqB_dnwrap", 15, 1);
        step("seqB_upwrap", 0, 1, 1, 0, 4'd15, 0, 4'd0); expect_out("seqB_upwrap", 1, 1);
        step("seqB_hold", 0, 0, 1, 1, 4'd15, 0, 4'd0);   expect_out("seqB_hold", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_step_counter.md
Name: parity_step_counter

Overview:
- Synchronous, parametrised odd/even counter. Steps by 2 through either the even or the odd values of a WIDTH-bit range.
- Adds up/down direction, a programmable upper limit, parallel load, count enable and a wrap pulse.
- Mode changes are sampled on the clock. There are no asynchronous or edge-triggered mode paths.
- Used as a sequence/address generator wherever interleaved even/odd indexing is needed.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per cycle while high.
- mode  in  1  0 = even sequence, 1 = odd sequence.
- dir  in  1  0 = count up, 1 = count down.
- lim  in  WIDTH  upper limit, inclusive before parity alignment.
- load  in  1  parallel-load strobe.
- load_val  in  WIDTH  load value.
- cnt  out  WIDTH  current count, registered.
- wrap  out  1  one-cycle pulse, registered, on a wrap step.

Behaviour:
- Reset: rst high at a clk edge sets cnt=0, mode_q=0, wrap=0. It overrides everything, including mid-sequence and on the same cycle as load or mode change.
- base = {0..0, mode_q}, i.e. 0 in even mode, 1 in odd mode.
- top = {lim[WIDTH-1:1], mode_q} if that value <= lim, otherwise that value minus 2. top is the largest value <= lim whose LSB equals mode_q.
- If lim < base (lim=0 in odd mode), then top = base.
- Priority per cycle (highest first): rst > mode change > load > en > hold.
- Mode change (mode != mode_q):
  - mode_q <= mode; cnt <= new base; wrap=0; load and en are ignored that cycle.
  - Latency 1 cycle, so after reset with mode=1 held, cnt=1 at the second edge.
- Load:
  - cnt <= {load_val[WIDTH-1:1], mode_q}, clamped to top if greater than top; wrap=0.
- en, up (dir=0):
  - If cnt >= top: cnt <= base, wrap=1.
  - Otherwise: cnt <= cnt+2, wrap=0.
  - Compute cnt+2 in WIDTH+1 bits so there is no silent overflow.
- en, down (dir=1):
  - If cnt <= base: cnt <= top, wrap=1.
  - Otherwise: cnt <= cnt-2, wrap=0.
- If top == base, each enabled step leaves cnt=base and asserts wrap.
- lim lowered below current cnt: the next up step wraps to base with wrap=1. The next down step goes to top with wrap=0, unless cnt <= base.
- dir may change every cycle; no state depends on previous direction.
- wrap is 0 on every cycle without a wrap step. It never stays high for two cycles except through consecutive wrap steps.
- cnt LSB always equals mode_q after the first post-reset cycle. This is an invariant and is asserted in the bench.

Decomposition:
- Shared package (or header) holds:
  - MODE_EVEN=0, MODE_ODD=1
  - DIR_UP=0, DIR_DOWN=1
- One natural sub-module, parity_limit_calc (combinational):
  - inputs: lim, mode_q
  - outputs: base, top
- The main block holds the mode_q, cnt and wrap registers and the priority mux.

Test Plan (WIDTH=4):
- Reset, mode=0, en=1, dir=0, lim=15 -> cnt 0,2,4,…,14, then 0 with wrap=1 for that one cycle only.
- mode 0->1 while cnt=6 -> next cycle cnt=1, wrap=0. Then 3,5,…,15, then 1 with wrap=1.
- mode=1, lim=10, dir=1, load with load_val=12 -> cnt=9 (parity-forced then clamped to top). Then 7,5,3,1, then 9 with wrap=1.
- mode=0, load=1, en=1 and mode 0->1 on the same cycle -> cnt=1, load ignored. rst=1 on that same cycle instead -> cnt=0, mode_q=0.
- mode=1, lim=0, en=1 for 3 cycles -> cnt stays 1, wrap=1 on each of the 3 cycles.
- mode=0, cnt=12, lim changed to 6, dir=0, one en pulse -> cnt=0, wrap=1. en=0 -> cnt holds, wrap=0.
